// File: rtl/fetch_control.sv
// Fetch stage control: PC register, F/D pipeline latch, redirect/stall FSM
// and a saturating count of taken redirects.
module fetch_control #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] branchTarget,
  input  logic        stall,
  input  logic [31:0] imemData,
  output logic [31:0] imemAddr,
  output logic [31:0] fdPC,
  output logic [31:0] fdPCPlusOne,
  output logic [31:0] fdInsn,
  output logic        fdValid,
  output logic        flushDX,
  output logic [1:0]  fetchState,
  output logic [15:0] redirectCount
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    FETCH    = 2'b00,
    STALL    = 2'b01,
    REDIRECT = 2'b10
  } stateT;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlusOne;
    logic [XLEN-1:0] insn;
    logic            valid;
  } fdLatchT;

  stateT            state;
  stateT            stateNext;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pcNext;
  logic [XLEN-1:0]  pcPlusOne;
  fdLatchT          fd;
  fdLatchT          fdNext;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic             effStall;

  // A stall only matters when the F/D latch holds a real instruction.
  assign pcPlusOne = pc + XLEN'(1);
  assign effStall  = stall & fd.valid;

  // Flush is combinational so the D/X latch sees it in the branch cycle.
  assign flushDX       = branch;
  assign imemAddr      = pc;
  assign fdPC          = fd.pc;
  assign fdPCPlusOne   = fd.pcPlusOne;
  assign fdInsn        = fd.insn;
  assign fdValid       = fd.valid;
  assign fetchState    = state;
  assign redirectCount = count;

  // Next-state and next-value logic: branch beats stall beats fetch.
  always_comb begin
    stateNext        = FETCH;
    pcNext           = pcPlusOne;
    fdNext.pc        = pc;
    fdNext.pcPlusOne = pcPlusOne;
    fdNext.insn      = imemData;
    fdNext.valid     = 1'b1;
    countNext        = count;
    if (branch) begin
      stateNext = REDIRECT;
      pcNext    = branchTarget;
      fdNext    = '0;
      if (count != '1) begin
        countNext = count + CNT_W'(1);
      end
    end else if (effStall) begin
      stateNext = STALL;
      pcNext    = pc;
      fdNext    = fd;
    end
  end

  // State, PC, F/D latch and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      fd    <= '0;
      count <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      fd    <= fdNext;
      count <= countNext;
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: the driver applies one input set per
// cycle, steps a behavioural model and queues the expected outputs; the
// monitor pops and compares just after each rising edge.
module tb_fetch_control;

  logic        clock;
  logic        reset;
  logic        branch;
  logic [31:0] branchTarget;
  logic        stall;
  logic [31:0] imemData;
  logic [31:0] imemAddr;
  logic [31:0] fdPC;
  logic [31:0] fdPCPlusOne;
  logic [31:0] fdInsn;
  logic        fdValid;
  logic        flushDX;
  logic [1:0]  fetchState;
  logic [15:0] redirectCount;

  fetch_control #(.RESET_PC(32'd0)) dut (
    .clock        (clock),
    .reset        (reset),
    .branch       (branch),
    .branchTarget (branchTarget),
    .stall        (stall),
    .imemData     (imemData),
    .imemAddr     (imemAddr),
    .fdPC         (fdPC),
    .fdPCPlusOne  (fdPCPlusOne),
    .fdInsn       (fdInsn),
    .fdValid      (fdValid),
    .flushDX      (flushDX),
    .fetchState   (fetchState),
    .redirectCount(redirectCount)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pcp1;
    logic [31:0] insn;
    logic        valid;
    logic        flush;
    logic [1:0]  st;
    logic [15:0] cnt;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;

  // Behavioural model state.
  logic [31:0] mPc;
  logic [31:0] mFdPc;
  logic [31:0] mFdPcp1;
  logic [31:0] mFdInsn;
  logic        mFdValid;
  logic [1:0]  mState;
  int          mCnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always begin
    @(posedge clock);
    #1;
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      chk("imemAddr",      imemAddr,               e.addr);
      chk("fdPC",          fdPC,                   e.pc);
      chk("fdPCPlusOne",   fdPCPlusOne,            e.pcp1);
      chk("fdInsn",        fdInsn,                 e.insn);
      chk("fdValid",       32'(fdValid),           32'(e.valid));
      chk("flushDX",       32'(flushDX),           32'(e.flush));
      chk("fetchState",    32'(fetchState),        32'(e.st));
      chk("redirectCount", 32'(redirectCount),     32'(e.cnt));
      if (fdValid === 1'b1) begin
        chk("fdPCPlusOne_rel", fdPCPlusOne, fdPC + 32'd1);
      end
    end
  end

  // One clock of stimulus: drive inputs, advance the model, queue expectation.
  task automatic cycle(input logic r, input logic b, input logic [31:0] t,
                       input logic s, input logic [31:0] d);
    expT e;
    @(negedge clock);
    reset        = r;
    branch       = b;
    branchTarget = t;
    stall        = s;
    imemData     = d;
    if (r) begin
      mPc = 32'd0; mFdPc = 32'd0; mFdPcp1 = 32'd0; mFdInsn = 32'd0;
      mFdValid = 1'b0; mState = 2'b00; mCnt = 0;
    end else if (b) begin
      mPc = t; mFdPc = 32'd0; mFdPcp1 = 32'd0; mFdInsn = 32'd0;
      mFdValid = 1'b0; mState = 2'b10;
      if (mCnt < 65535) mCnt = mCnt + 1;
    end else if (s && mFdValid) begin
      mState = 2'b01;
    end else begin
      mFdPc = mPc; mFdPcp1 = mPc + 32'd1; mFdInsn = d; mFdValid = 1'b1;
      mPc = mPc + 32'd1; mState = 2'b00;
    end
    e.addr  = mPc;
    e.pc    = mFdPc;
    e.pcp1  = mFdPcp1;
    e.insn  = mFdInsn;
    e.valid = mFdValid;
    e.flush = b;
    e.st    = mState;
    e.cnt   = 16'(mCnt);
    expQ.push_back(e);
  endtask

  initial begin
    reset = 1'b0; branch = 1'b0; branchTarget = 32'd0; stall = 1'b0; imemData = 32'd0;
    mPc = 32'd0; mFdPc = 32'd0; mFdPcp1 = 32'd0; mFdInsn = 32'd0;
    mFdValid = 1'b0; mState = 2'b00; mCnt = 0;

    // Reset then free-run.
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'h0A000005);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'h0A000005);
    // Run until PC = 7, then redirect to 0x40.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, $urandom);
    cycle(1'b0, 1'b1, 32'h40, 1'b0, $urandom);
    // Stall on a bubble is ignored.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, $urandom);
    // Stall with valid latch for 3 cycles, then branch with stall.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, $urandom);
    cycle(1'b0, 1'b1, 32'h1234, 1'b1, $urandom);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, $urandom);
    // PC wrap.
    cycle(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, $urandom);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, $urandom);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, $urandom);
    // Back-to-back branches take the newest target.
    cycle(1'b0, 1'b1, 32'h100, 1'b0, $urandom);
    cycle(1'b0, 1'b1, 32'h200, 1'b1, $urandom);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, $urandom);
    // Reset mid-redirect, with branch and stall also asserted.
    cycle(1'b0, 1'b1, 32'h300, 1'b0, $urandom);
    cycle(1'b1, 1'b1, 32'h400, 1'b1, $urandom);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), $urandom,
            $urandom_range(0, 1) == 1, $urandom);
    end
    // Counter saturation.
    cycle(1'b1, 1'b0, 32'd0, 1'b0, $urandom);
    for (int i = 0; i < 65539; i++) begin
      cycle(1'b0, 1'b1, $urandom, $urandom_range(0, 1) == 1, $urandom);
    end
    // Reset mid-stall.
    cycle(1'b0, 1'b0, 32'd0, 1'b0, $urandom);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, $urandom);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, $urandom);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, $urandom);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, $urandom);
    // Drain the scoreboard.
    @(negedge clock);
    branch = 1'b0; stall = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
